// File: rtl/spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : spi_mem_ctrl
// Brief    : SPI slave front-end for the 256x8 command memory. Deserialises
//            10-bit command words and serialises read-data bytes on MISO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_mem_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ss_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid
);
    localparam int                   c_word_w    = DATA_WIDTH + 2;
    localparam logic [CNT_WIDTH-1:0] c_word_bits = CNT_WIDTH'(c_word_w);
    localparam logic [CNT_WIDTH-1:0] c_last_bit  = CNT_WIDTH'(c_word_w - 1);
    localparam logic [CNT_WIDTH-1:0] c_tx_rest   = CNT_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]  tx_cnt_q, tx_cnt_d;
    logic                  tx_used_q, tx_used_d;
    logic [c_word_w-1:0]   shift_q, shift_d;
    logic [c_word_w-1:0]   rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  miso_q, miso_d;
    logic                  rd_addr_pending_q, rd_addr_pending_d;

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        tx_cnt_d          = tx_cnt_q;
        tx_used_d         = tx_used_q;
        shift_d           = shift_q;
        rx_data_d         = rx_data_q;
        rx_valid_d        = 1'b0;
        miso_d            = 1'b0;
        rd_addr_pending_d = rd_addr_pending_q;

        // The pending-address flag follows the completed word's opcode, not the state.
        if (rx_valid_q) begin
            case (rx_data_q[c_word_w-1:c_word_w-2])
                2'b10:   rd_addr_pending_d = 1'b1;
                2'b11:   rd_addr_pending_d = 1'b0;
                default: rd_addr_pending_d = rd_addr_pending_q;
            endcase
        end

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                tx_cnt_d  = '0;
                tx_used_d = 1'b0;
                if (!ss_n) begin
                    state_d = CHK_CMD;
                end
            end
            CHK_CMD, WRITE, READ_ADD, READ_DATA: begin
                if (ss_n) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    tx_cnt_d  = '0;
                    tx_used_d = 1'b0;
                end else if (state_q == CHK_CMD) begin
                    shift_d = {shift_q[c_word_w-2:0], mosi};
                    cnt_d   = CNT_WIDTH'(1);
                    if (!mosi) begin
                        state_d = WRITE;
                    end else if (rd_addr_pending_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end else if (cnt_q != c_word_bits) begin
                    shift_d = {shift_q[c_word_w-2:0], mosi};
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == c_last_bit) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = {shift_q[c_word_w-2:0], mosi};
                    end
                end else if (state_q == READ_DATA) begin
                    // Only the first tx_valid after the word is accepted per frame.
                    if (!tx_used_q) begin
                        if (tx_valid) begin
                            tx_used_d = 1'b1;
                            miso_d    = tx_data[DATA_WIDTH-1];
                            shift_d   = {tx_data[DATA_WIDTH-2:0], 3'b000};
                            tx_cnt_d  = c_tx_rest;
                        end
                    end else if (tx_cnt_q != '0) begin
                        miso_d   = shift_q[c_word_w-1];
                        shift_d  = {shift_q[c_word_w-2:0], 1'b0};
                        tx_cnt_d = tx_cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            tx_cnt_q          <= '0;
            tx_used_q         <= 1'b0;
            shift_q           <= '0;
            rx_data_q         <= '0;
            rx_valid_q        <= 1'b0;
            miso_q            <= 1'b0;
            rd_addr_pending_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            tx_cnt_q          <= tx_cnt_d;
            tx_used_q         <= tx_used_d;
            shift_q           <= shift_d;
            rx_data_q         <= rx_data_d;
            rx_valid_q        <= rx_valid_d;
            miso_q            <= miso_d;
            rd_addr_pending_q <= rd_addr_pending_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_mem_ctrl
// Brief    : Scoreboard bench for spi_mem_ctrl with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_mem_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int         n_vec = 0;
    int         n_err = 0;
    bit         exp_miso_q[$];
    logic [9:0] exp_rx_q[$];
    logic [9:0] last_word = 10'h000;
    bit         pending = 1'b0;

    always #5 clk = ~clk;

    spi_mem_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    // Monitor: consumes one expected MISO value per clock and one expected word per rx_valid.
    always @(negedge clk) begin : monitor
        bit         em;
        logic [9:0] ew;
        if (exp_miso_q.size() > 0) begin
            em = exp_miso_q.pop_front();
            n_vec++;
            if (miso !== em) begin
                n_err++;
                $display("FAIL miso: got %b want %b at %0t", miso, em, $time);
            end
            n_vec++;
            if (rx_data !== last_word) begin
                n_err++;
                $display("FAIL rx_data_hold: got %h want %h at %0t", rx_data, last_word, $time);
            end
        end
        if (rx_valid !== 1'b0) begin
            n_vec++;
            if (exp_rx_q.size() == 0) begin
                n_err++;
                $display("FAIL rx_valid_unexpected: got %b want 0 at %0t", rx_valid, $time);
            end else begin
                ew = exp_rx_q.pop_front();
                if (rx_valid !== 1'b1 || rx_data !== ew) begin
                    n_err++;
                    $display("FAIL rx_word: got %h want %h at %0t", rx_data, ew, $time);
                end
            end
        end
    end

    task automatic step(input bit rst_v, input bit ss_v, input bit mosi_v,
                        input bit txv, input logic [7:0] txd, input bit exp_m);
        rst_n    = rst_v;
        ss_n     = ss_v;
        mosi     = mosi_v;
        tx_valid = txv;
        tx_data  = txd;
        @(posedge clk);
        #1;
        exp_miso_q.push_back(exp_m);
    endtask

    // One SPI frame: ss_n low for L edges (E0..E(L-1)), then high for gap edges.
    // tx_valid pulses at edges tx_at/spur_at (-1 = none); rst_at applies reset at that edge.
    task automatic run_frame(input logic [9:0] w, input int L, input int gap,
                             input int tx_at, input logic [7:0] txd,
                             input int spur_at, input logic [7:0] spur_d, input int rst_at);
        int         eff;
        bit         complete;
        bit         elig;
        int         tf;
        logic [7:0] fd;
        bit         stopped;
        bit         exp_m;
        bit         txv;
        logic [7:0] tdat;
        eff      = (rst_at >= 0 && rst_at < L) ? rst_at : L;
        complete = (eff >= 11);
        elig     = complete && w[9] && pending;
        tf       = -1;
        fd       = 8'h00;
        if (spur_at >= 11 && spur_at < eff) begin
            tf = spur_at;
            fd = spur_d;
        end
        if (tx_at >= 11 && tx_at < eff && (tf < 0 || tx_at <= tf)) begin
            tf = tx_at;
            fd = txd;
        end
        stopped = 1'b0;
        for (int j = 0; j < L + gap; j++) begin
            if (!stopped) begin
                if (j == rst_at) begin
                    step(1'b0, 1'b1, 1'($urandom), 1'b0, 8'h00, 1'b0);
                    pending   = 1'b0;
                    last_word = 10'h000;
                    for (int k = 0; k < gap; k++) begin
                        step(1'b1, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
                    end
                    stopped = 1'b1;
                end else begin
                    txv  = 1'b0;
                    tdat = 8'($urandom);
                    if (j == tx_at) begin
                        txv  = 1'b1;
                        tdat = txd;
                    end else if (j == spur_at) begin
                        txv  = 1'b1;
                        tdat = spur_d;
                    end
                    exp_m = 1'b0;
                    if (elig && tf >= 0 && j >= tf && j <= tf + 7 && j < L) begin
                        exp_m = fd[7 - (j - tf)];
                    end
                    step(1'b1, (j < L) ? 1'b0 : 1'b1,
                         (j >= 1 && j <= 10) ? w[10 - j] : 1'($urandom),
                         txv, tdat, exp_m);
                    if (j == 10 && complete) begin
                        exp_rx_q.push_back(w);
                        last_word = w;
                    end
                    if (j == 11 && complete) begin
                        if (w[9:8] == 2'b10) pending = 1'b1;
                        else if (w[9:8] == 2'b11) pending = 1'b0;
                    end
                end
            end
        end
        n_vec++;
        if (exp_rx_q.size() != 0) begin
            n_err++;
            $display("FAIL rx_valid_missing: got no pulse want word %h", exp_rx_q[0]);
            exp_rx_q.delete();
        end
    endtask

    initial begin : driver
        logic [9:0] w;
        int         L;
        int         tx_at;
        int         spur_at;
        rst_n    = 1'b0;
        ss_n     = 1'b1;
        mosi     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        run_frame(10'h02A, 12, 2, -1, 8'h00, -1, 8'h00, -1);
        run_frame(10'h15C, 12, 2,  5, 8'hAA, -1, 8'h00, -1);
        run_frame(10'h22A, 12, 2, -1, 8'h00, -1, 8'h00, -1);
        run_frame(10'h300, 20, 2, 12, 8'h5C, 15, 8'hFF, -1);
        run_frame(10'h1FF,  6, 2, -1, 8'h00, -1, 8'h00, -1);
        run_frame(10'h001, 12, 2, -1, 8'h00, -1, 8'h00, -1);
        run_frame(10'h300, 20, 2, 12, 8'hFF, -1, 8'h00, -1);
        run_frame(10'h22A, 12, 2, -1, 8'h00, -1, 8'h00, -1);
        run_frame(10'h300, 20, 2, 11, 8'hA5, -1, 8'h00, 14);
        run_frame(10'h300, 20, 2, 11, 8'hFF, -1, 8'h00, -1);

        for (int f = 0; f < 80; f++) begin
            w       = 10'($urandom);
            L       = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10))
                                                  : int'($urandom_range(11, 24));
            tx_at   = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(9, 14));
            spur_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, L + 1)) : -1;
            run_frame(w, L, int'($urandom_range(1, 3)), tx_at, 8'($urandom),
                      spur_at, 8'($urandom),
                      ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 20)) : -1);
        end

        repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
